// File: rtl/ball_tracker_pkg.sv
// Shared types, widths and tuning constants for the ball tracker and its landing predictor.
package ball_tracker_pkg;

  localparam int XW = 6;
  localparam int YW = 5;
  localparam int VW = 8;
  localparam int CW = 13;

  localparam int COLS        = 40;
  localparam int ROWS        = 30;
  localparam int MIN_COUNT   = 8;
  localparam int MAX_JUMP    = 6;
  localparam int ACQ_FRAMES  = 2;
  localparam int LOST_FRAMES = 4;
  localparam int TARGET_ROW  = 29;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_COAST   = 2'd3
  } state_t;

  typedef logic signed [VW-1:0] sval_t;

  localparam sval_t X_MAX    = sval_t'(COLS - 1);
  localparam sval_t Y_MAX    = sval_t'(ROWS - 1);
  localparam sval_t JUMP_MAX = sval_t'(MAX_JUMP);
  localparam sval_t TGT_ROW  = sval_t'(TARGET_ROW);

  function automatic sval_t from_x(input logic [XW-1:0] x);
    return sval_t'({{(VW-XW){1'b0}}, x});
  endfunction

  function automatic sval_t from_y(input logic [YW-1:0] y);
    return sval_t'({{(VW-YW){1'b0}}, y});
  endfunction

  function automatic sval_t abs_s(input sval_t v);
    if (v[VW-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/ball_predictor.sv
// Iterative landing-column engine: one step per cycle, reflecting off the side walls,
// until the ball row reaches the target row.
module ball_predictor
  import ball_tracker_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          start,
  input  logic          abort,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [VW-1:0] vx0,
  input  logic [VW-1:0] vy0,
  output logic          busy,
  output logic          done,
  output logic [XW-1:0] x_out
);

  sval_t         x_r, y_r, vx_r, vy_r;
  logic          busy_r, done_r;
  logic [XW-1:0] x_out_r;

  sval_t src_x_s, src_y_s, src_vx_s, src_vy_s;
  sval_t sum_x_s, nx_s, nvx_s, ny_s;
  logic  hit_s;

  // One step from the start point (first cycle) or the running state, with one wall reflection.
  always_comb begin
    if (start) begin
      src_x_s  = from_x(x0);
      src_y_s  = from_y(y0);
      src_vx_s = sval_t'(vx0);
      src_vy_s = sval_t'(vy0);
    end else begin
      src_x_s  = x_r;
      src_y_s  = y_r;
      src_vx_s = vx_r;
      src_vy_s = vy_r;
    end
    sum_x_s = src_x_s + src_vx_s;
    ny_s    = src_y_s + src_vy_s;
    if (sum_x_s[VW-1]) begin
      nx_s  = -sum_x_s;
      nvx_s = -src_vx_s;
    end else if (sum_x_s > X_MAX) begin
      nx_s  = X_MAX + X_MAX - sum_x_s;
      nvx_s = -src_vx_s;
    end else begin
      nx_s  = sum_x_s;
      nvx_s = src_vx_s;
    end
    hit_s = (ny_s >= TGT_ROW);
  end

  // Step engine state; abort drops any work in flight, including a completion.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      x_r     <= 8'sd0;
      y_r     <= 8'sd0;
      vx_r    <= 8'sd0;
      vy_r    <= 8'sd0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      x_out_r <= 6'd0;
    end else if (abort) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start || busy_r) begin
      x_r    <= nx_s;
      y_r    <= ny_s;
      vx_r   <= nvx_s;
      vy_r   <= src_vy_s;
      busy_r <= !hit_s;
      done_r <= hit_s;
      if (hit_s) begin
        x_out_r <= nx_s[XW-1:0];
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign x_out = x_out_r;

endmodule

// File: rtl/ball_tracker.sv
// Per-frame acquire/track/coast tracker with gating and clamped extrapolation; drives the
// landing predictor and publishes its result.
module ball_tracker
  import ball_tracker_pkg::*;
(
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          FRAME_VALID,
  input  logic [XW-1:0] BALL_X,
  input  logic [YW-1:0] BALL_Y,
  input  logic [CW-1:0] BALL_COUNT,
  output logic [XW-1:0] TRACK_X,
  output logic [YW-1:0] TRACK_Y,
  output logic [VW-1:0] VEL_X,
  output logic [VW-1:0] VEL_Y,
  output logic [1:0]    STATE,
  output logic [XW-1:0] PRED_X,
  output logic          PRED_VALID
);

  state_t        state_r;
  logic [XW-1:0] track_x_r;
  logic [YW-1:0] track_y_r;
  sval_t         vel_x_r, vel_y_r;
  logic [2:0]    acq_cnt_r, miss_cnt_r;
  logic          upd_r;
  logic [XW-1:0] pred_x_r;
  logic          pred_valid_r;

  logic          det_s, gate_s, accept_s, zero_s, pred_ok_s, start_s, abort_s;
  sval_t         ex_s, ey_s, dvx_s, dvy_s, cvx_s, cvy_s;
  logic [XW-1:0] cx_s;
  logic [YW-1:0] cy_s;
  logic [2:0]    acq_next_s, miss_next_s;
  logic          pred_busy_s, pred_done_s;
  logic [XW-1:0] pred_xo_s;

  // Detection, gating against the expected position, and clamped coast extrapolation.
  always_comb begin
    det_s    = (BALL_COUNT >= CW'(MIN_COUNT));
    ex_s     = from_x(track_x_r) + vel_x_r;
    ey_s     = from_y(track_y_r) + vel_y_r;
    gate_s   = (abs_s(from_x(BALL_X) - ex_s) <= JUMP_MAX) &&
               (abs_s(from_y(BALL_Y) - ey_s) <= JUMP_MAX);
    accept_s = det_s && gate_s;
    dvx_s    = from_x(BALL_X) - from_x(track_x_r);
    dvy_s    = from_y(BALL_Y) - from_y(track_y_r);
    if (ex_s[VW-1]) begin
      cx_s  = 6'd0;
      cvx_s = 8'sd0;
    end else if (ex_s > X_MAX) begin
      cx_s  = X_MAX[XW-1:0];
      cvx_s = 8'sd0;
    end else begin
      cx_s  = ex_s[XW-1:0];
      cvx_s = vel_x_r;
    end
    if (ey_s[VW-1]) begin
      cy_s  = 5'd0;
      cvy_s = 8'sd0;
    end else if (ey_s > Y_MAX) begin
      cy_s  = Y_MAX[YW-1:0];
      cvy_s = 8'sd0;
    end else begin
      cy_s  = ey_s[YW-1:0];
      cvy_s = vel_y_r;
    end
    acq_next_s  = acq_cnt_r + 3'd1;
    miss_next_s = miss_cnt_r + 3'd1;
    zero_s      = FRAME_VALID && !accept_s &&
                  ((state_r == ST_ACQUIRE) ||
                   ((state_r == ST_COAST) && (miss_next_s >= 3'(LOST_FRAMES))));
    pred_ok_s   = (state_r == ST_TRACK) && !vel_y_r[VW-1] && (vel_y_r != 8'sd0) &&
                  (from_y(track_y_r) < TGT_ROW);
    start_s     = upd_r && pred_ok_s;
    abort_s     = FRAME_VALID && (pred_busy_s || start_s);
  end

  // Tracker state machine; all tracker registers move only on a frame.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r    <= ST_IDLE;
      track_x_r  <= 6'd0;
      track_y_r  <= 5'd0;
      vel_x_r    <= 8'sd0;
      vel_y_r    <= 8'sd0;
      acq_cnt_r  <= 3'd0;
      miss_cnt_r <= 3'd0;
    end else if (FRAME_VALID) begin
      case (state_r)
        ST_IDLE: begin
          if (det_s) begin
            track_x_r <= BALL_X;
            track_y_r <= BALL_Y;
            vel_x_r   <= 8'sd0;
            vel_y_r   <= 8'sd0;
            acq_cnt_r <= 3'd1;
            state_r   <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (accept_s) begin
            track_x_r <= BALL_X;
            track_y_r <= BALL_Y;
            vel_x_r   <= dvx_s;
            vel_y_r   <= dvy_s;
            if (acq_next_s >= 3'(ACQ_FRAMES)) begin
              acq_cnt_r <= 3'd0;
              state_r   <= ST_TRACK;
            end else begin
              acq_cnt_r <= acq_next_s;
            end
          end else begin
            track_x_r <= 6'd0;
            track_y_r <= 5'd0;
            vel_x_r   <= 8'sd0;
            vel_y_r   <= 8'sd0;
            acq_cnt_r <= 3'd0;
            state_r   <= ST_IDLE;
          end
        end
        ST_TRACK: begin
          if (accept_s) begin
            track_x_r <= BALL_X;
            track_y_r <= BALL_Y;
            vel_x_r   <= dvx_s;
            vel_y_r   <= dvy_s;
          end else begin
            track_x_r  <= cx_s;
            track_y_r  <= cy_s;
            vel_x_r    <= cvx_s;
            vel_y_r    <= cvy_s;
            miss_cnt_r <= 3'd1;
            state_r    <= ST_COAST;
          end
        end
        ST_COAST: begin
          if (accept_s) begin
            track_x_r  <= BALL_X;
            track_y_r  <= BALL_Y;
            vel_x_r    <= dvx_s;
            vel_y_r    <= dvy_s;
            miss_cnt_r <= 3'd0;
            state_r    <= ST_TRACK;
          end else if (zero_s) begin
            track_x_r  <= 6'd0;
            track_y_r  <= 5'd0;
            vel_x_r    <= 8'sd0;
            vel_y_r    <= 8'sd0;
            miss_cnt_r <= 3'd0;
            state_r    <= ST_IDLE;
          end else begin
            track_x_r  <= cx_s;
            track_y_r  <= cy_s;
            vel_x_r    <= cvx_s;
            vel_y_r    <= cvy_s;
            miss_cnt_r <= miss_next_s;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Publish predictions; a restart or loss of the predicting condition withdraws PRED_VALID.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      upd_r        <= 1'b0;
      pred_x_r     <= 6'd0;
      pred_valid_r <= 1'b0;
    end else begin
      upd_r <= FRAME_VALID;
      if (zero_s) begin
        pred_x_r     <= 6'd0;
        pred_valid_r <= 1'b0;
      end else if (start_s || !pred_ok_s) begin
        pred_valid_r <= 1'b0;
      end else if (pred_done_s && !FRAME_VALID) begin
        pred_x_r     <= pred_xo_s;
        pred_valid_r <= 1'b1;
      end
    end
  end

  ball_predictor u_predictor (
    .CLK   (CLK),
    .RST_N (RST_N),
    .start (start_s),
    .abort (abort_s),
    .x0    (track_x_r),
    .y0    (track_y_r),
    .vx0   (vel_x_r),
    .vy0   (vel_y_r),
    .busy  (pred_busy_s),
    .done  (pred_done_s),
    .x_out (pred_xo_s)
  );

  assign TRACK_X    = track_x_r;
  assign TRACK_Y    = track_y_r;
  assign VEL_X      = vel_x_r;
  assign VEL_Y      = vel_y_r;
  assign STATE      = state_r;
  assign PRED_X     = pred_x_r;
  assign PRED_VALID = pred_valid_r;

endmodule
